// File: rtl/gm_test_sequencer_pkg.sv
// rtl/gm_test_sequencer_pkg.sv - shared types, widths, taps and MISR step for the gate-model self-test.
package gm_test_pkg;

  localparam int GM_IN_W  = 22;
  localparam int GM_OUT_W = 10;

  // x^22+x^21+1 and x^10+x^7+1: feedback taken from these bit positions.
  localparam logic [GM_IN_W-1:0]  LFSR_TAPS = 22'h30_0000;
  localparam logic [GM_OUT_W-1:0] MISR_TAPS = 10'h240;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    APPLY   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } gm_state_e;

  function automatic logic [GM_OUT_W-1:0] misr_next(input logic [GM_OUT_W-1:0] misr,
                                                    input logic [GM_OUT_W-1:0] resp);
    return {misr[GM_OUT_W-2:0], ^(misr & MISR_TAPS)} ^ resp;
  endfunction

endpackage

// File: rtl/gm_test_sequencer_if.sv
// rtl/gm_test_sequencer_if.sv - host and gate-model signal bundle; pass/fail exist with GM_GOLDEN_CHECK_EN.
interface gm_test_sequencer_if
  import gm_test_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic                start;
  logic                abort;
  logic [GM_IN_W-1:0]  seed;
  logic [GM_IN_W-1:0]  gm_in;
  logic [GM_OUT_W-1:0] gm_out;
  logic                busy;
  logic                done;
  logic [GM_OUT_W-1:0] signature;
  logic [CNT_W-1:0]    pattern_idx;
`ifdef GM_GOLDEN_CHECK_EN
  logic                pass;
  logic                fail;
`endif

  modport master (
    input  start, abort, seed, gm_out,
    output gm_in, busy, done, signature, pattern_idx
`ifdef GM_GOLDEN_CHECK_EN
    , output pass, fail
`endif
  );

  modport slave (
    output start, abort, seed, gm_out,
    input  gm_in, busy, done, signature, pattern_idx
`ifdef GM_GOLDEN_CHECK_EN
    , input pass, fail
`endif
  );

endinterface

// File: rtl/gm_test_sequencer_lfsr22.sv
// rtl/gm_test_sequencer_lfsr22.sv - seedable 22-bit Fibonacci LFSR; a zero seed loads 22'h000001.
module gm_lfsr22
  import gm_test_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               advance,
  input  logic [GM_IN_W-1:0] seed,
  output logic [GM_IN_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= (seed == '0) ? GM_IN_W'(1) : seed;
    end else if (advance) begin
      q <= {q[GM_IN_W-2:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/gm_test_sequencer.sv
// rtl/gm_test_sequencer.sv - LFSR-driven self-test of the Gatter22 gate model with MISR compaction.
// Optional golden compare with pass/fail outputs under GM_GOLDEN_CHECK_EN.
module gm_test_sequencer
  import gm_test_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_PATTERNS  = 256,
  parameter int CNT_W         = 16
`ifdef GM_GOLDEN_CHECK_EN
  , parameter logic [GM_OUT_W-1:0] GOLDEN_SIG = 10'h000
`endif
)(
  input logic                 clk,
  input logic                 rst_n,
  gm_test_sequencer_if.master bus
);

  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(NUM_PATTERNS - 1);

  gm_state_e           state_q, state_d;
  logic [7:0]          settle_q;
  logic [CNT_W-1:0]    idx_q;
  logic [GM_OUT_W-1:0] misr_q;
  logic [GM_OUT_W-1:0] sig_q;
  logic                done_q;
  logic [GM_IN_W-1:0]  lfsr_q;
  logic                busy_w, run_start, run_abort, capture, last_vec;

  assign busy_w    = (state_q == APPLY) || (state_q == CAPTURE);
  assign run_start = bus.start && !busy_w;
  assign run_abort = bus.abort && busy_w;
  assign capture   = (state_q == CAPTURE) && !run_abort;
  assign last_vec  = (idx_q == LAST_IDX);

  // The last vector is never advanced past, so gm_in keeps showing it in DONE.
  gm_lfsr22 u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (run_start),
    .advance (capture && !last_vec),
    .seed    (bus.seed),
    .q       (lfsr_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (bus.start) state_d = APPLY;
      APPLY: begin
        if (bus.abort)                     state_d = IDLE;
        else if (settle_q == SETTLE_LAST)  state_d = CAPTURE;
      end
      CAPTURE: begin
        if (bus.abort)     state_d = IDLE;
        else if (last_vec) state_d = DONE;
        else               state_d = APPLY;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q <= '0;
      idx_q    <= '0;
      misr_q   <= '0;
      sig_q    <= '0;
      done_q   <= 1'b0;
    end else if (run_start) begin
      settle_q <= '0;
      idx_q    <= '0;
      misr_q   <= '0;
      done_q   <= 1'b0;
    end else if (run_abort) begin
      settle_q <= '0;
      idx_q    <= '0;
      misr_q   <= '0;
      sig_q    <= '0;
    end else begin
      case (state_q)
        APPLY: settle_q <= settle_q + 8'd1;
        CAPTURE: begin
          misr_q <= misr_next(misr_q, bus.gm_out);
          if (!last_vec) begin
            idx_q    <= idx_q + CNT_W'(1);
            settle_q <= '0;
          end
        end
        // Result and done are published together one edge after DONE is entered.
        DONE: begin
          sig_q  <= misr_q;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef GM_GOLDEN_CHECK_EN
  logic pass_q, fail_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else if (run_start) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else if (state_q == DONE) begin
      pass_q <= (misr_q == GOLDEN_SIG);
      fail_q <= (misr_q != GOLDEN_SIG);
    end
  end

  assign bus.pass = pass_q;
  assign bus.fail = fail_q;
`endif

  assign bus.gm_in       = lfsr_q;
  assign bus.busy        = busy_w;
  assign bus.done        = done_q;
  assign bus.signature   = sig_q;
  assign bus.pattern_idx = idx_q;

endmodule
